// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave Wishbone B4 classic arbiter.
// Master 0 is the LIMB(EC) bridge and master 1 is the second requester.
// Ownership alternates round-robin between contending masters. A master
// keeps the bus for its whole cyc burst. A per-transfer watchdog ends a
// stalled strobe with a one-cycle error.
module wb_arbiter2 #(
    parameter int ADR_WIDTH = 36,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_cyc_i,
    output logic [31:0]          m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_cyc_i,
    output logic [31:0]          m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_stb_o,
    output logic                 s_cyc_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           grant
);

    // The grant encoding doubles as the one-hot owner flag on the grant port.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } grant_t;

    // A zero TIMEOUT switches the watchdog off entirely.
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam bit          WDOG_EN   = (TIMEOUT != 0);

    grant_t      state_q;
    grant_t      state_nxt;
    logic        last_served_q;
    logic        last_served_nxt;
    logic [15:0] wdog_q;
    logic        fire_q;
    logic        to_flag_q;

    logic        own0;
    logic        own1;
    logic        owned;
    logic        own_cyc;
    logic        own_stb;
    logic        suppress;
    logic        wd_err;
    logic        xfer_end;

    // The watchdog count saturates rather than wraps, so a long stall with the
    // watchdog off can never alias back onto the TIMEOUT value.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    assign own0  = (state_q == OWN0);
    assign own1  = (state_q == OWN1);
    assign owned = own0 | own1;
    assign grant = state_q;

    assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

    // The bus is cut during the watchdog error cycle and afterwards until the
    // owner gives up cyc. Only registered state feeds this gate, so a slave
    // that acks combinationally from stb cannot form a loop through it.
    assign suppress = to_flag_q | fire_q;

    // A slave termination in the firing cycle beats the watchdog error.
    assign wd_err   = fire_q & ~s_ack_i & ~s_err_i;
    assign xfer_end = s_ack_i | s_err_i;

    // Forward the owner's request to the slave; nothing leaves while idle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        unique case (state_q)
            OWN0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
            end
            OWN1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
            end
            default: begin
                s_adr_o = '0;
                s_dat_o = '0;
                s_sel_o = '0;
                s_we_o  = 1'b0;
            end
        endcase
        s_cyc_o = own_cyc & ~suppress;
        s_stb_o = own_stb & own_cyc & ~suppress;
    end

    // Route the slave response to the owner only; the other master sees zeros.
    always_comb begin
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (own0) begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | wd_err;
        end
        if (own1) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | wd_err;
        end
    end

    // Next owner: round-robin on contention, burst lock while the owner holds cyc.
    always_comb begin
        state_nxt       = state_q;
        last_served_nxt = last_served_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_served_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_nxt = OWN0;
                end else if (m1_cyc_i) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_nxt       = IDLE;
                    last_served_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_nxt       = IDLE;
                    last_served_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner and fairness registers; reset leaves master 1 as last served so master 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_nxt;
            last_served_q <= last_served_nxt;
        end
    end

    // Watchdog: count unacked strobe cycles, fire once on TIMEOUT, then hold the bus off until release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            fire_q    <= 1'b0;
            to_flag_q <= 1'b0;
        end else begin
            if (!owned || !s_stb_o || xfer_end) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= sat_inc16(wdog_q);
            end

            fire_q <= WDOG_EN && owned && s_stb_o && !xfer_end && (wdog_q == TIMEOUT_W);

            if (state_nxt == IDLE) begin
                to_flag_q <= 1'b0;
            end else if (wd_err) begin
                to_flag_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed bench for wb_arbiter2. One instance uses TIMEOUT=8,
// a second with TIMEOUT=0 shares the same stimulus for the disabled-watchdog case.
module tb_wb_arbiter2;

    localparam int AW = 36;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [31:0]   m0_dat, m1_dat;
    logic [3:0]    m0_sel, m1_sel;
    logic          m0_we, m0_stb, m0_cyc;
    logic          m1_we, m1_stb, m1_cyc;
    logic [31:0]   s_dat_i;
    logic          s_ack_i, s_err_i;

    logic [31:0]   m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_stb_o, s_cyc_o;
    logic [1:0]    grant;

    logic [31:0]   nt_m0_dat_o, nt_m1_dat_o;
    logic          nt_m0_ack_o, nt_m0_err_o, nt_m1_ack_o, nt_m1_err_o;
    logic [AW-1:0] nt_s_adr_o;
    logic [31:0]   nt_s_dat_o;
    logic [3:0]    nt_s_sel_o;
    logic          nt_s_we_o, nt_s_stb_o, nt_s_cyc_o;
    logic [1:0]    nt_grant;

    int   total;
    int   bad;
    logic err_seen;
    logic grant_lost;

    wb_arbiter2 #(.ADR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant(grant)
    );

    wb_arbiter2 #(.ADR_WIDTH(AW), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_dat_o(nt_m0_dat_o), .m0_ack_o(nt_m0_ack_o), .m0_err_o(nt_m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_dat_o(nt_m1_dat_o), .m1_ack_o(nt_m1_ack_o), .m1_err_o(nt_m1_err_o),
        .s_adr_o(nt_s_adr_o), .s_dat_o(nt_s_dat_o), .s_sel_o(nt_s_sel_o),
        .s_we_o(nt_s_we_o), .s_stb_o(nt_s_stb_o), .s_cyc_o(nt_s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant(nt_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0; err_seen = 1'b0; grant_lost = 1'b0;
        rst_n = 1'b0;
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
        s_dat_i = 32'h55; s_ack_i = 1'b1; s_err_i = 1'b0;

        // reset state, with a stray slave ack present
        tick; tick;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_m0_ack", m0_ack_o, 1'b0);
        chk("rst_m0_dat", m0_dat_o, 32'h0);
        chk("rst_m1_ack", m1_ack_o, 1'b0);
        rst_n = 1'b1;
        tick;
        chk("idle_ack_ignored", m0_ack_o, 1'b0);
        chk("idle_grant", grant, 2'b00);
        s_ack_i = 1'b0; s_dat_i = 32'h0;

        // single master write
        m0_adr = 36'h0_1234_5678; m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
        m0_we = 1'b1; m0_stb = 1'b1; m0_cyc = 1'b1;
        #1;
        chk("t1_no_grant_yet", grant, 2'b00);
        chk("t1_s_cyc_pre", s_cyc_o, 1'b0);
        tick;
        chk("t1_grant", grant, 2'b01);
        chk("t1_s_adr", s_adr_o, 36'h0_1234_5678);
        chk("t1_s_dat", s_dat_o, 32'hDEADBEEF);
        chk("t1_s_sel", s_sel_o, 4'hF);
        chk("t1_s_we", s_we_o, 1'b1);
        chk("t1_s_stb", s_stb_o, 1'b1);
        chk("t1_s_cyc", s_cyc_o, 1'b1);
        chk("t1_no_ack_yet", m0_ack_o, 1'b0);
        tick; tick;
        s_ack_i = 1'b1;
        #1;
        chk("t1_m0_ack", m0_ack_o, 1'b1);
        chk("t1_m1_ack", m1_ack_o, 1'b0);
        tick;
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack_i = 1'b0;
        #1;
        chk("t1_ack_single", m0_ack_o, 1'b0);
        chk("t1_cyc_drop", s_cyc_o, 1'b0);
        chk("t1_grant_hold", grant, 2'b01);
        tick;
        chk("t1_release", grant, 2'b00);

        // contention from fresh reset
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
        m0_adr = 36'h100; m1_adr = 36'h200; m0_we = 1'b0; m1_we = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        chk("c_first_m0", grant, 2'b01);
        chk("c_adr_m0", s_adr_o, 36'h100);
        s_ack_i = 1'b1; s_dat_i = 32'hAAAA_0001;
        #1;
        chk("c_m0_ack", m0_ack_o, 1'b1);
        chk("c_m0_dat", m0_dat_o, 32'hAAAA_0001);
        chk("c_m1_ack_blk", m1_ack_o, 1'b0);
        chk("c_m1_dat_blk", m1_dat_o, 32'h0);
        tick;
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack_i = 1'b0;
        #1;
        chk("c_cyc_drop", s_cyc_o, 1'b0);
        tick;
        chk("c_idle_gap", grant, 2'b00);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        chk("c_second_m1", grant, 2'b10);
        chk("c_adr_m1", s_adr_o, 36'h200);
        s_ack_i = 1'b1; s_dat_i = 32'hBBBB_0002;
        #1;
        chk("c_m1_ack", m1_ack_o, 1'b1);
        chk("c_m1_dat", m1_dat_o, 32'hBBBB_0002);
        chk("c_m0_ack_blk", m0_ack_o, 1'b0);
        chk("c_m0_dat_blk", m0_dat_o, 32'h0);
        tick;
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack_i = 1'b0;
        tick;
        chk("c_idle_gap2", grant, 2'b00);
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick;
        chk("c_rr_back_m0", grant, 2'b01);
        s_ack_i = 1'b1;
        tick;
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack_i = 1'b0;
        tick;
        chk("c_idle_gap3", grant, 2'b00);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        chk("b_grant_m1", grant, 2'b10);

        // burst lock: m1 reads 1..4 while m0 keeps requesting
        for (int k = 1; k <= 4; k++) begin
            s_ack_i = 1'b1; s_dat_i = 32'(k);
            #1;
            chk("b_m1_dat", m1_dat_o, 64'(k));
            chk("b_m1_ack", m1_ack_o, 1'b1);
            chk("b_lock", grant, 2'b10);
            chk("b_m0_ack_blk", m0_ack_o, 1'b0);
            tick;
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack_i = 1'b0; s_dat_i = 32'h0;
        #1;
        chk("b_still_m1", grant, 2'b10);
        tick;
        chk("b_idle", grant, 2'b00);
        tick;
        chk("b_then_m0", grant, 2'b01);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick;
        chk("b_m0_release", grant, 2'b00);

        // watchdog, TIMEOUT=8, slave never acks
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        chk("wd_grant", grant, 2'b01);
        chk("wd_stb_start", s_stb_o, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick;
            chk("wd_no_err_early", m0_err_o, 1'b0);
        end
        chk("wd_cyc_before", s_cyc_o, 1'b1);
        tick;
        chk("wd_err_9th", m0_err_o, 1'b1);
        chk("wd_cyc_forced", s_cyc_o, 1'b0);
        chk("wd_stb_forced", s_stb_o, 1'b0);
        chk("wd_m1_err", m1_err_o, 1'b0);
        tick;
        chk("wd_err_once", m0_err_o, 1'b0);
        chk("wd_cyc_supp", s_cyc_o, 1'b0);
        tick; tick;
        chk("wd_cyc_supp_late", s_cyc_o, 1'b0);
        chk("wd_err_quiet", m0_err_o, 1'b0);
        chk("wd_grant_kept", grant, 2'b01);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick;
        chk("wd_release", grant, 2'b00);

        // watchdog with ack landing on the 9th cycle
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick;
        chk("wa_grant", grant, 2'b01);
        for (int i = 1; i <= 8; i++) tick;
        tick;
        s_ack_i = 1'b1;
        #1;
        chk("wa_ack_wins", m0_ack_o, 1'b1);
        chk("wa_no_err", m0_err_o, 1'b0);
        tick;
        s_ack_i = 1'b0;
        #1;
        chk("wa_cyc_live", s_cyc_o, 1'b1);
        chk("wa_no_err_after", m0_err_o, 1'b0);

        // reset in the middle of an m0 transfer
        chk("rm_stb_before", s_stb_o, 1'b1);
        rst_n = 1'b0; s_ack_i = 1'b1;
        tick;
        chk("rm_grant", grant, 2'b00);
        chk("rm_s_cyc", s_cyc_o, 1'b0);
        chk("rm_s_stb", s_stb_o, 1'b0);
        chk("rm_m0_ack", m0_ack_o, 1'b0);
        chk("rm_m0_err", m0_err_o, 1'b0);
        chk("rm_m1_ack", m1_ack_o, 1'b0);
        m1_cyc = 1'b1; m1_stb = 1'b1; rst_n = 1'b1; s_ack_i = 1'b0;
        tick;
        chk("rm_m0_first", grant, 2'b01);

        // TIMEOUT=0: stall for 1000 cycles without any error
        rst_n = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 1000; i++) begin
            tick;
            if (nt_m0_err_o !== 1'b0) err_seen = 1'b1;
            if (nt_grant !== 2'b01) grant_lost = 1'b1;
        end
        chk("nt_no_err", err_seen, 1'b0);
        chk("nt_grant_held", grant_lost, 1'b0);
        chk("nt_grant_end", nt_grant, 2'b01);
        chk("nt_s_cyc", nt_s_cyc_o, 1'b1);
        s_ack_i = 1'b1; s_err_i = 1'b1;
        #1;
        chk("nt_ack_pass", nt_m0_ack_o, 1'b1);
        chk("nt_err_pass", nt_m0_err_o, 1'b1);
        chk("nt_m1_err_blk", nt_m1_err_o, 1'b0);
        s_ack_i = 1'b0; s_err_i = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
